// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity encodings and receiver FSM states.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push alongside a pull is accepted even when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pull,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    empty,
    output logic                    full,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign do_pop  = pull && !empty;
    assign do_push = push && (!full || pull);
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LVL_W'(1);
            end else if (do_pop && !do_push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, sticky error flags and a show-ahead receive FIFO.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 24
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_W-1:0]              div,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop2,
    input  logic                          rx,
    input  logic                          pull,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(3);

    rx_state_e            state;
    logic                 sync1;
    logic                 rx_s;
    logic                 rx_prev;
    logic                 fall;
    logic [DIV_W-1:0]     div_eff;
    logic [DIV_W-1:0]     div_l;
    logic [DIV_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 par_bad;
    logic                 par_en_l;
    logic                 par_odd_l;
    logic                 stop2_l;
    logic                 stop_second;
    logic                 stop_bad;
    logic                 push_q;

    assign div_eff = (div < DIV_MIN) ? DIV_MIN : div;
    assign fall    = rx_prev && !rx_s;
    assign busy    = (state != ST_IDLE);

    // Two-flop synchroniser plus history bit for start-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            div_l       <= '0;
            idx         <= '0;
            shreg       <= '0;
            par_acc     <= 1'b0;
            par_bad     <= 1'b0;
            par_en_l    <= 1'b0;
            par_odd_l   <= 1'b0;
            stop2_l     <= 1'b0;
            stop_second <= 1'b0;
            stop_bad    <= 1'b0;
            push_q      <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            push_q <= 1'b0;
            // Clear first so a same-cycle set event below takes priority.
            if (clr_err) begin
                frame_err  <= 1'b0;
                parity_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (push_q && par_bad) begin
                parity_err <= 1'b1;
            end
            if (push_q && full && !pull) begin
                overrun <= 1'b1;
            end

            if (!enable) begin
                state <= ST_IDLE;
            end else if (state == ST_IDLE) begin
                if (fall) begin
                    state     <= ST_START;
                    cnt       <= div_eff >> 1;
                    div_l     <= div_eff;
                    par_en_l  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
                    par_odd_l <= (parity_mode == PAR_ODD);
                    stop2_l   <= stop2;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - DIV_W'(1);
            end else begin
                cnt <= div_l;
                case (state)
                    ST_START: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            idx     <= '0;
                            par_acc <= 1'b0;
                            par_bad <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ rx_s;
                        idx     <= idx + IDX_W'(1);
                        if (idx == IDX_W'(DATA_BITS - 1)) begin
                            state       <= par_en_l ? ST_PARITY : ST_STOP;
                            stop_second <= 1'b0;
                            stop_bad    <= 1'b0;
                        end
                    end
                    ST_PARITY: begin
                        par_bad <= ((par_acc ^ rx_s) != par_odd_l);
                        state   <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (stop2_l && !stop_second) begin
                            stop_second <= 1'b1;
                            stop_bad    <= !rx_s;
                        end else begin
                            state <= ST_IDLE;
                            if (stop_bad || !rx_s) begin
                                frame_err <= 1'b1;
                            end else begin
                                push_q <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_q),
        .pull  (pull),
        .din   (shreg),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .level (level)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scoreboard bench for uart_rx_fifo: framing, parity, errors, FIFO overrun/wrap and aborts.
module tb_uart_rx_fifo;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned DIV_W      = 24;
    localparam int          BIT_CLKS   = 10;

    logic                        clk = 1'b0;
    logic                        reset;
    logic                        enable;
    logic [DIV_W-1:0]            div;
    logic [1:0]                  parity_mode;
    logic                        stop2;
    logic                        rx;
    logic                        pull;
    logic                        clr_err;
    logic [DATA_BITS-1:0]        dout;
    logic                        empty;
    logic                        full;
    logic [$clog2(FIFO_DEPTH):0] level;
    logic                        busy;
    logic                        frame_err;
    logic                        parity_err;
    logic                        overrun;

    int checks   = 0;
    int failures = 0;
    int fall_at;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DIV_W      (DIV_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div         (div),
        .parity_mode (parity_mode),
        .stop2       (stop2),
        .rx          (rx),
        .pull        (pull),
        .clr_err     (clr_err),
        .dout        (dout),
        .empty       (empty),
        .full        (full),
        .level       (level),
        .busy        (busy),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check(tag, 32'({frame_err, parity_err, overrun}), 32'(exp));
    endtask

    // Pops the scoreboard head, compares it with the show-ahead output, then pulls.
    task automatic pull_word(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_empty"}, 32'(empty), 32'd0);
            check(tag, 32'(dout), 32'(e));
        end
        pull = 1'b1;
        @(negedge clk);
        pull = 1'b0;
    endtask

    // Drives one frame, one cycle per iteration; records the first cycle where empty falls.
    task automatic send_frame(input logic [7:0] data, input bit use_par, input bit par_bit,
                              input bit stop_val, input int pull_at);
        logic [10:0] bits;
        int          nb;
        logic        was_empty;
        logic [7:0]  e;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = data[i];
        nb = 9;
        if (use_par) begin
            bits[nb] = par_bit;
            nb++;
        end
        bits[nb] = stop_val;
        nb++;
        fall_at = -1;
        for (int c = 0; c < nb * BIT_CLKS; c++) begin
            rx   = bits[c / BIT_CLKS];
            pull = (c == pull_at);
            if (c == pull_at) begin
                e = exp_q.pop_front();
                check("pull_in_push_cycle", 32'(dout), 32'(e));
            end
            was_empty = empty;
            @(negedge clk);
            if (was_empty && !empty && fall_at < 0) fall_at = c;
        end
        pull = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b1;
        div         = DIV_W'(9);
        parity_mode = 2'd0;
        stop2       = 1'b0;
        rx          = 1'b1;
        pull        = 1'b0;
        clr_err     = 1'b0;
        idle(3);
        reset = 1'b0;
        @(negedge clk);

        check("reset_empty", 32'(empty), 32'd1);
        check("reset_full", 32'(full), 32'd0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check_flags("reset_flags", 3'b000);

        // 8N1 0x55 with latency measured from the first edge that sees rx low
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1);
        exp_q.push_back(8'h55);
        check("t1_latency", 32'(fall_at), 32'd98);
        check_flags("t1_flags", 3'b000);
        pull_word("t1_data");
        check("t1_empty_after", 32'(empty), 32'd1);

        // Even parity: correct then wrong parity bit
        parity_mode = 2'd1;
        send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1);
        exp_q.push_back(8'h07);
        check("t2_par_ok", 32'(parity_err), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b1, -1);
        exp_q.push_back(8'h07);
        check("t2_par_bad", 32'(parity_err), 32'd1);
        check("t2_level", 32'(level), 32'd2);
        pulse_clr();
        check("t2_par_cleared", 32'(parity_err), 32'd0);
        check("t2_level_kept", 32'(level), 32'd2);
        pull_word("t2_word0");
        pull_word("t2_word1");
        parity_mode = 2'd0;

        // Stop bit low, then held-low break line
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        check("t3_frame_err", 32'(frame_err), 32'd1);
        check("t3_level", 32'(level), 32'd0);
        pulse_clr();
        rx = 1'b0;
        idle(200);
        check("t3_break_no_err", 32'(frame_err), 32'd0);
        check("t3_break_busy", 32'(busy), 32'd0);
        check("t3_break_level", 32'(level), 32'd0);
        rx = 1'b1;
        idle(20);

        // Overrun: five words into a four-deep FIFO
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 1'b0, 1'b0, 1'b1, -1);
            if (b <= 4) exp_q.push_back(8'(b));
        end
        check("t4_full", 32'(full), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_level", 32'(level), 32'd4);
        for (int b = 1; b <= 4; b++) pull_word("t4_data");
        check("t4_empty", 32'(empty), 32'd1);
        check("t4_level_zero", 32'(level), 32'd0);
        pulse_clr();
        check("t4_ovr_cleared", 32'(overrun), 32'd0);

        // Same, but the fifth push coincides with a pull
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 1'b0, 1'b0, 1'b1, -1);
            exp_q.push_back(8'(b));
        end
        send_frame(8'h05, 1'b0, 1'b0, 1'b1, 98);
        exp_q.push_back(8'h05);
        check("t4b_no_overrun", 32'(overrun), 32'd0);
        check("t4b_full", 32'(full), 32'd1);
        check("t4b_level", 32'(level), 32'd4);
        for (int b = 2; b <= 5; b++) pull_word("t4b_data");
        check("t4b_empty", 32'(empty), 32'd1);

        // Three-clock glitch is a false start
        rx = 1'b0;
        idle(3);
        check("t5_busy_start", 32'(busy), 32'd1);
        rx = 1'b1;
        idle(20);
        check("t5_busy_idle", 32'(busy), 32'd0);
        check("t5_level", 32'(level), 32'd0);
        check_flags("t5_flags", 3'b000);

        // Abort mid-DATA with enable, then a clean frame
        rx = 1'b0;
        idle(BIT_CLKS);
        rx = 1'b1;
        idle(30);
        check("t6_busy_data", 32'(busy), 32'd1);
        enable = 1'b0;
        @(negedge clk);
        check("t6_busy_abort", 32'(busy), 32'd0);
        enable = 1'b1;
        idle(30);
        check("t6_level", 32'(level), 32'd0);
        check_flags("t6_flags", 3'b000);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1, -1);
        exp_q.push_back(8'hA3);
        pull_word("t6_data");
        check_flags("t6_flags_after", 3'b000);

        // Reset mid-frame with a word stored and an error pending
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
        rx = 1'b1;
        idle(20);
        check("t7_pre_level", 32'(level), 32'd1);
        check("t7_pre_frame_err", 32'(frame_err), 32'd1);
        rx = 1'b0;
        idle(40);
        check("t7_pre_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        rx    = 1'b1;
        #1;
        check("t7_empty", 32'(empty), 32'd1);
        check("t7_full", 32'(full), 32'd0);
        check("t7_level", 32'(level), 32'd0);
        check("t7_dout", 32'(dout), 32'd0);
        check("t7_busy", 32'(busy), 32'd0);
        check_flags("t7_flags", 3'b000);
        @(negedge clk);
        reset = 1'b0;
        idle(5);

        send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1);
        exp_q.push_back(8'h96);
        pull_word("t8_data");
        check("t8_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised hardware UART receiver with a built-in receive FIFO. It is the fixed-function successor to the PIO-program UART RX and uses the same clk/reset, pin-in and pull/empty/full conventions as pio.
- Configurable data width, parity, stop bits and bit period.
- Error flags: framing, parity and overrun.
- Placed beside pio, taking its input from a gpio_in bit and read by the host through a pull strobe.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)
DIV_W, 24, width of the bit-period divider

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
enable  input  1  receiver enable; 0 aborts any frame in progress
div  input  DIV_W  bit period = div+1 clocks; values <3 are treated as 3
parity_mode  input  2  0/3 none, 1 even, 2 odd
stop2  input  1  1 = two stop bits checked
rx  input  1  serial line (idle high), asynchronous to clk
pull  input  1  pop strobe; ignored when empty
clr_err  input  1  clears all sticky error flags
dout  output  DATA_BITS  FIFO head (show-ahead); valid when !empty
empty  output  1  FIFO empty
full  output  1  FIFO full
level  output  clog2(FIFO_DEPTH)+1  FIFO occupancy
busy  output  1  FSM not in IDLE
frame_err  output  1  sticky: a stop bit was sampled 0
parity_err  output  1  sticky: parity mismatch
overrun  output  1  sticky: a word was dropped because the FIFO was full

Behaviour:
- Reset values:
  - FSM = IDLE; both rx synchroniser flops = 1.
  - empty=1, full=0, level=0, dout=0, busy=0, all error flags 0.
- rx passes through a 2-flop synchroniser to give rx_s; a falling edge is detected on rx_s against its previous value.
- div, parity_mode and stop2 are latched on the start edge; changing them mid-frame has no effect until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on enable && falling edge → START; cnt = div_l>>1.
  - Every state except IDLE decrements cnt each cycle and samples rx_s when cnt==0, then reloads cnt = div_l.
  - START sample: rx_s=1 → false start, return to IDLE with no flags. rx_s=0 → DATA, bit index 0.
  - DATA: shift the sampled bit in LSB first. After DATA_BITS samples → PARITY if parity is enabled, else STOP.
  - PARITY: XOR of data bits plus the sampled bit must be 0 (even) or 1 (odd); a mismatch marks the frame parity-bad.
  - STOP: sample 1 stop bit, or 2 if stop2. Any stop sample = 0 sets frame_err and the word is discarded. Otherwise the word is pushed, even if parity-bad (parity_err is set on push).
  - STOP then returns to IDLE. A new frame needs a fresh falling edge, so a held-low break line yields exactly one frame error.
- Sample timing:
  - First (start) sample = edge cycle + (div_l>>1) + 1.
  - Each later sample is div_l+1 clocks after the previous one.
  - The push is registered 1 cycle after the final stop sample.
- enable=0 in any state → IDLE next cycle; the partial frame is dropped and no flags are set.
- FIFO:
  - Push is accepted when !full || pull in the same cycle. A simultaneous push and pull on a full FIFO succeeds with no overrun.
  - Push while full && !pull: the word is dropped and overrun is set.
  - pull when empty is ignored, and level never underflows.
  - Simultaneous push+pull when empty: the push takes effect and the pull is ignored, so level becomes 1.
  - Pointers wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH).
- Error flags:
  - If a set event and clr_err occur in the same cycle, set wins.
  - clr_err does not affect FIFO contents.
- A reset asserted mid-frame clears everything immediately, FIFO included.

Decomposition:
- Shared package uart_pkg:
  - parity-mode constants: PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
  - FSM state enum.
- One sub-module, sync_fifo (WIDTH, DEPTH): push/pull/dout/level/full/empty with show-ahead read. It is reusable for a future uart_tx.

Test Plan:
- div=9, 8N1, rx sends 0x55 → empty falls exactly 98 clocks after the first clk edge sampling rx=0; dout=0x55; no error flags.
- div=9, even parity, byte 0x07 with parity bit 1 → word 0x07 pushed, parity_err=0. Same byte with parity bit 0 → word 0x07 pushed, parity_err=1. clr_err → parity_err=0.
- 8N1 frame with stop bit held 0 → no push, frame_err=1, level unchanged. rx stays low for 200 clocks → no second error or frame.
- Overrun and wrap:
  - FIFO_DEPTH=4: send 5 bytes 0x01..0x05 with no pull → full=1, overrun=1; pulls return 0x01..0x04, then empty=1.
  - Repeat with a pull in the push cycle → no overrun.
- rx low pulse of 3 clocks (div=9) → false start, busy returns to 0, no push, no flags.
- Abort:
  - enable=0 mid-DATA → IDLE next cycle with no push; a following clean frame 0xA3 is received correctly.
  - reset mid-frame → all outputs at reset values.
